pc_fetch_sequencer: RTL and testbench

//   Owns the program counter and sequences instruction fetch over a req/ack memory handshake.
//   Per completed fetch, PC advances by STEP through an enabled +STEP adder, or loads a redirect target.

---
 rtl/pc_seq_pkg.sv | 13 +
 rtl/pc_fetch_sequencer_adder.sv | 13 +
 rtl/pc_fetch_sequencer.sv | 153 +++++++++++++++
 tb/tb_pc_fetch_sequencer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and defaults for the program-counter fetch sequencer.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_HALTED = 2'd2
  } pc_seq_state_e;

  localparam int          STEP_DEF     = 2;
  localparam logic [15:0] RESET_PC_DEF = 16'h0000;

endpackage

// File: rtl/pc_fetch_sequencer_adder.sv
// Enabled +STEP incrementer on the sequential fetch path; wraps modulo 2^WIDTH.
module pc_step_adder #(
  parameter int WIDTH = 16,
  parameter int STEP  = 2
) (
  input  logic [WIDTH-1:0] a,
  input  logic             en,
  output logic [WIDTH-1:0] res
);

  assign res = en ? a + WIDTH'(STEP) : a;

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Program counter owner: issues req/ack instruction fetches, applies redirects,
// stalls and halts, and reports each delivered fetch and misaligned-target faults.
module pc_fetch_sequencer
  import pc_seq_pkg::*;
#(
  parameter int               WIDTH    = 16,
  parameter int               STEP     = STEP_DEF,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEF)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             halt_req,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ack,
  output logic             instr_valid,
  output logic [WIDTH-1:0] instr_pc,
  output logic             fault,
  output logic             halted,
  output pc_seq_state_e    dbg_state
);

  pc_seq_state_e    state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             pend_valid_q, pend_valid_d;
  logic [WIDTH-1:0] pend_pc_q, pend_pc_d;
  logic             out_pend_q, out_pend_d;
  logic             halt_q, halt_d;
  logic             instr_valid_q, instr_valid_d;
  logic [WIDTH-1:0] instr_pc_q, instr_pc_d;
  logic             fault_q, fault_d;

  logic             req;
  logic             xfer;
  logic             misaligned;
  logic             redir_ok;
  logic             step_en;
  logic             halt_any;
  logic [WIDTH-1:0] step_res;

  // Handshake: imem_req/imem_addr are held stable from the cycle req rises
  // until the ack cycle (out_pend_q masks stall); a transfer is req & ack,
  // and the next address is presented the cycle after the transfer.
  always_comb begin
    req        = (state_q == S_FETCH) && (!stall || out_pend_q);
    xfer       = req && imem_ack;
    misaligned = (redirect_pc % WIDTH'(STEP)) != '0;
    redir_ok   = redirect_valid && !misaligned;
    step_en    = xfer && !redir_ok && !pend_valid_q;
    halt_any   = halt_q || halt_req;
  end

  pc_step_adder #(.WIDTH(WIDTH), .STEP(STEP)) u_step (
    .a   (pc_q),
    .en  (step_en),
    .res (step_res)
  );

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_valid_d  = pend_valid_q;
    pend_pc_d     = pend_pc_q;
    out_pend_d    = 1'b0;
    halt_d        = 1'b0;
    instr_valid_d = 1'b0;
    instr_pc_d    = instr_pc_q;
    fault_d       = redirect_valid && misaligned;

    case (state_q)
      S_IDLE: begin
        if (redir_ok) pc_d = redirect_pc;
        if (run) state_d = S_FETCH;
      end
      S_HALTED: begin
        if (redir_ok) pc_d = redirect_pc;
        if (run && !halt_req) state_d = S_FETCH;
      end
      S_FETCH: begin
        halt_d = halt_any;
        if (xfer) begin
          pend_valid_d = 1'b0;
          if (redir_ok) begin
            pc_d          = redirect_pc;
            instr_valid_d = 1'b1;
            instr_pc_d    = pc_q;
          end else if (pend_valid_q) begin
            // A redirect arrived while this fetch was in flight: squash it.
            pc_d = pend_pc_q;
          end else begin
            pc_d          = step_res;
            instr_valid_d = 1'b1;
            instr_pc_d    = pc_q;
          end
          if (halt_any) begin
            state_d = S_HALTED;
            halt_d  = 1'b0;
          end
        end else if (req) begin
          out_pend_d = 1'b1;
          if (redir_ok) begin
            pend_valid_d = 1'b1;
            pend_pc_d    = redirect_pc;
          end
        end else begin
          if (redir_ok) pc_d = redirect_pc;
          if (halt_any) begin
            state_d = S_HALTED;
            halt_d  = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      pend_valid_q  <= 1'b0;
      pend_pc_q     <= '0;
      out_pend_q    <= 1'b0;
      halt_q        <= 1'b0;
      instr_valid_q <= 1'b0;
      instr_pc_q    <= '0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_valid_q  <= pend_valid_d;
      pend_pc_q     <= pend_pc_d;
      out_pend_q    <= out_pend_d;
      halt_q        <= halt_d;
      instr_valid_q <= instr_valid_d;
      instr_pc_q    <= instr_pc_d;
      fault_q       <= fault_d;
    end
  end

  assign imem_req    = req;
  assign imem_addr   = pc_q;
  assign instr_valid = instr_valid_q;
  assign instr_pc    = instr_pc_q;
  assign fault       = fault_q;
  assign halted      = (state_q == S_HALTED);
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Scenario bench for pc_fetch_sequencer: directed tasks plus an instr_pc scoreboard.
module tb_pc_fetch_sequencer;
  import pc_seq_pkg::*;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          run = 1'b0;
  logic          halt_req = 1'b0;
  logic          stall = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [W-1:0]  redirect_pc = '0;
  logic          imem_req;
  logic [W-1:0]  imem_addr;
  logic          imem_ack = 1'b0;
  logic          instr_valid;
  logic [W-1:0]  instr_pc;
  logic          fault;
  logic          halted;
  pc_seq_state_e dbg_state;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  pc_fetch_sequencer #(.WIDTH(W), .STEP(2), .RESET_PC(16'h0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .run            (run),
    .halt_req       (halt_req),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .instr_valid    (instr_valid),
    .instr_pc       (instr_pc),
    .fault          (fault),
    .halted         (halted),
    .dbg_state      (dbg_state)
  );

  always #5 clk = ~clk;

  // Scoreboard: every delivered fetch must match the oldest expected address.
  always @(negedge clk) begin
    if (instr_valid === 1'b1) begin
      logic [W-1:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected instr_pc=%h required=no delivery", instr_pc);
      end else begin
        e = exp_q.pop_front();
        if (instr_pc !== e) begin
          failures++;
          $display("FAIL sb_instr_pc got=%h required=%h", instr_pc, e);
        end
      end
    end
  end

  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; halt_req = 1'b0; stall = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0; imem_ack = 1'b0;
    nxt();
    nxt();
    rst = 1'b0;
  endtask

  // Loads a start address in IDLE and enters FETCH on the same edge.
  task automatic start_at(input logic [W-1:0] a);
    redirect_pc = a; redirect_valid = 1'b1; run = 1'b1;
    nxt();
    redirect_valid = 1'b0; run = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b1; imem_ack = 1'b1;
    nxt();
    nxt();
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%b required=0", imem_req); end
    checks++; if (imem_addr !== 16'h0000) begin failures++; $display("FAIL rst_addr got=%h required=0000", imem_addr); end
    checks++; if (instr_valid !== 1'b0 || fault !== 1'b0 || halted !== 1'b0) begin
      failures++; $display("FAIL rst_flags got=%b%b%b required=000", instr_valid, fault, halted);
    end
    checks++; if (instr_pc !== 16'h0000) begin failures++; $display("FAIL rst_instr_pc got=%h required=0000", instr_pc); end
    checks++; if (dbg_state !== S_IDLE) begin failures++; $display("FAIL rst_state got=%0d required=%0d", dbg_state, S_IDLE); end
    do_reset();
  endtask

  task automatic test_sequential();
    do_reset();
    run = 1'b1; imem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      nxt();
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== W'(2 * i)) begin
        failures++; $display("FAIL seq_addr%0d got=%b/%h required=1/%h", i, imem_req, imem_addr, W'(2 * i));
      end
      exp_q.push_back(W'(2 * i));
    end
    nxt();
    imem_ack = 1'b0; run = 1'b0;
    checks++; if (imem_addr !== 16'h0008) begin failures++; $display("FAIL seq_addr4 got=%h required=0008", imem_addr); end
    nxt();
  endtask

  task automatic test_wrap();
    do_reset();
    start_at(16'hFFFE);
    imem_ack = 1'b1;
    checks++; if (imem_addr !== 16'hFFFE) begin failures++; $display("FAIL wrap_start got=%h required=fffe", imem_addr); end
    exp_q.push_back(16'hFFFE);
    nxt();
    imem_ack = 1'b0;
    checks++; if (imem_addr !== 16'h0000 || fault !== 1'b0) begin
      failures++; $display("FAIL wrap_addr got=%h/%b required=0000/0", imem_addr, fault);
    end
    nxt();
  endtask

  task automatic test_pending_redirect();
    do_reset();
    start_at(16'h0010);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0010) begin
      failures++; $display("FAIL pend_issue got=%b/%h required=1/0010", imem_req, imem_addr);
    end
    redirect_pc = 16'h0040; redirect_valid = 1'b1;
    nxt();
    redirect_valid = 1'b0; stall = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0010) begin
      failures++; $display("FAIL pend_stable got=%b/%h required=1/0010", imem_req, imem_addr);
    end
    nxt();
    imem_ack = 1'b1; stall = 1'b0;
    nxt();
    imem_ack = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL pend_squash got=%b required=0", instr_valid); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0040) begin
      failures++; $display("FAIL pend_target got=%b/%h required=1/0040", imem_req, imem_addr);
    end
    nxt();
  endtask

  task automatic test_stall_halt();
    do_reset();
    run = 1'b1; stall = 1'b1;
    nxt();
    run = 1'b0;
    checks++; if (imem_req !== 1'b0 || dbg_state !== S_FETCH) begin
      failures++; $display("FAIL stall_req got=%b/%0d required=0/%0d", imem_req, dbg_state, S_FETCH);
    end
    redirect_pc = 16'h0100; redirect_valid = 1'b1;
    nxt();
    redirect_valid = 1'b0;
    checks++; if (imem_addr !== 16'h0100 || imem_req !== 1'b0) begin
      failures++; $display("FAIL stall_redir got=%b/%h required=0/0100", imem_req, imem_addr);
    end
    halt_req = 1'b1;
    nxt();
    halt_req = 1'b0;
    checks++; if (halted !== 1'b1 || imem_req !== 1'b0) begin
      failures++; $display("FAIL stall_halt got=%b/%b required=1/0", halted, imem_req);
    end
    stall = 1'b0;
    nxt();
  endtask

  task automatic test_redirect_at_ack();
    do_reset();
    start_at(16'h0020);
    imem_ack = 1'b1; redirect_pc = 16'h0080; redirect_valid = 1'b1;
    exp_q.push_back(16'h0020);
    nxt();
    imem_ack = 1'b0; redirect_valid = 1'b0;
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0020) begin
      failures++; $display("FAIL ack_redir_deliver got=%b/%h required=1/0020", instr_valid, instr_pc);
    end
    checks++; if (imem_addr !== 16'h0080) begin failures++; $display("FAIL ack_redir_addr got=%h required=0080", imem_addr); end
    nxt();
  endtask

  task automatic test_misaligned();
    do_reset();
    start_at(16'h0030);
    imem_ack = 1'b1; redirect_pc = 16'h0031; redirect_valid = 1'b1;
    exp_q.push_back(16'h0030);
    nxt();
    imem_ack = 1'b0; redirect_valid = 1'b0;
    checks++; if (fault !== 1'b1 || imem_addr !== 16'h0032) begin
      failures++; $display("FAIL mis_fault got=%b/%h required=1/0032", fault, imem_addr);
    end
    nxt();
    checks++; if (fault !== 1'b0) begin failures++; $display("FAIL mis_pulse got=%b required=0", fault); end
    redirect_pc = 16'h0035; redirect_valid = 1'b1;
    nxt();
    redirect_valid = 1'b0;
    checks++; if (fault !== 1'b1 || imem_addr !== 16'h0032) begin
      failures++; $display("FAIL mis_pend_fault got=%b/%h required=1/0032", fault, imem_addr);
    end
    imem_ack = 1'b1;
    exp_q.push_back(16'h0032);
    nxt();
    imem_ack = 1'b0;
    checks++; if (instr_valid !== 1'b1 || imem_addr !== 16'h0034) begin
      failures++; $display("FAIL mis_pend_keep got=%b/%h required=1/0034", instr_valid, imem_addr);
    end
    nxt();
  endtask

  task automatic test_halt_resume_reset();
    do_reset();
    start_at(16'h0050);
    halt_req = 1'b1;
    nxt();
    halt_req = 1'b0;
    checks++; if (halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0050) begin
      failures++; $display("FAIL halt_wait got=%b/%b/%h required=0/1/0050", halted, imem_req, imem_addr);
    end
    nxt();
    imem_ack = 1'b1;
    exp_q.push_back(16'h0050);
    nxt();
    imem_ack = 1'b0;
    checks++; if (halted !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b1) begin
      failures++; $display("FAIL halt_done got=%b/%b/%b required=1/0/1", halted, imem_req, instr_valid);
    end
    run = 1'b1; halt_req = 1'b1;
    nxt();
    halt_req = 1'b0;
    checks++; if (halted !== 1'b1) begin failures++; $display("FAIL halt_wins got=%b required=1", halted); end
    nxt();
    run = 1'b0;
    checks++; if (halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0052) begin
      failures++; $display("FAIL resume got=%b/%b/%h required=0/1/0052", halted, imem_req, imem_addr);
    end
    imem_ack = 1'b1;
    exp_q.push_back(16'h0052);
    nxt();
    imem_ack = 1'b0;
    nxt();
    rst = 1'b1;
    nxt();
    checks++; if (imem_req !== 1'b0 || imem_addr !== 16'h0000) begin
      failures++; $display("FAIL rst_mid got=%b/%h required=0/0000", imem_req, imem_addr);
    end
    rst = 1'b0; imem_ack = 1'b1;
    nxt();
    imem_ack = 1'b0;
    checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b0 || dbg_state !== S_IDLE) begin
      failures++; $display("FAIL late_ack got=%b/%b/%0d required=0/0/%0d", instr_valid, imem_req, dbg_state, S_IDLE);
    end
    nxt();
  endtask

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout got=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    test_reset();
    test_sequential();
    test_wrap();
    test_pending_redirect();
    test_stall_halt();
    test_redirect_at_ack();
    test_misaligned();
    test_halt_resume_reset();
    nxt();
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL sb_drain got=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
